// File: rtl/pio_target_responder.sv
`default_nettype none
// ============================================================================
// Module   : pio_target_responder
// Brief    : Endpoint PIO target servicing MemRd/MemWr/IO requests against a
//            DW-addressed BAR memory and issuing Cpl/CplD completion requests.
// Revision : 1.0 - initial release
// ============================================================================
module pio_target_responder #(
    parameter logic [31:0] BAR_BASE = 32'h8000_0000,
    parameter int unsigned MEM_DW   = 256
) (
    input  logic        user_clk,
    input  logic        reset_n,
    input  logic        user_lnk_up,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_type,
    input  logic [7:0]  req_tag,
    input  logic [15:0] req_rid,
    input  logic [63:0] req_addr,
    input  logic [31:0] req_data,
    output logic        cpl_start,
    output logic        cpl_type,
    output logic [2:0]  cpl_status,
    output logic [7:0]  cpl_tag,
    output logic [15:0] cpl_rid,
    output logic [6:0]  cpl_lower_addr,
    output logic [31:0] cpl_data,
    input  logic        cpl_done,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic [7:0]  err_count
);

    localparam int unsigned c_idx_w = $clog2(MEM_DW);
    localparam logic [63:0] c_base  = {32'h0, BAR_BASE};
    localparam logic [63:0] c_span  = 64'(MEM_DW) * 64'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DECODE   = 2'd1,
        ST_RDATA    = 2'd2,
        ST_CPL_WAIT = 2'd3
    } state_t;

    state_t              r_state;
    logic [2:0]          r_type;
    logic [7:0]          r_tag;
    logic [15:0]         r_rid;
    logic [63:0]         r_addr;
    logic [31:0]         r_data;
    logic                r_ur;
    logic [31:0]         r_rdata;
    logic [31:0]         r_mem [MEM_DW];

    logic                w_accept;
    logic [63:0]         w_addr;
    logic [63:0]         w_off;
    logic                w_hit;
    logic [c_idx_w-1:0]  w_idx;
    logic                w_mem_we;

    assign req_ready = reset_n & user_lnk_up & (r_state == ST_IDLE);
    assign w_accept  = req_valid & req_ready;
    assign w_addr    = r_addr & ~64'd3;
    assign w_off     = w_addr - c_base;
    assign w_hit     = (w_addr >= c_base) && (w_off < c_span);
    assign w_idx     = w_off[c_idx_w+1:2];
    assign w_mem_we  = reset_n & user_lnk_up & (r_state == ST_DECODE) &
                       ~r_type[2] & r_type[0] & w_hit;

    // Memory is not reset; the read port runs every cycle so the word for the
    // latched address is ready one cycle after ST_DECODE.
    always_ff @(posedge user_clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_data;
        end
        r_rdata <= r_mem[w_idx];
    end

    always_ff @(posedge user_clk) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_type         <= 3'd0;
            r_tag          <= 8'd0;
            r_rid          <= 16'd0;
            r_addr         <= 64'd0;
            r_data         <= 32'd0;
            r_ur           <= 1'b0;
            cpl_start      <= 1'b0;
            cpl_type       <= 1'b0;
            cpl_status     <= 3'd0;
            cpl_tag        <= 8'd0;
            cpl_rid        <= 16'd0;
            cpl_lower_addr <= 7'd0;
            cpl_data       <= 32'd0;
            wr_count       <= 16'd0;
            rd_count       <= 16'd0;
            err_count      <= 8'd0;
        end else if (!user_lnk_up) begin
            // Link loss abandons any in-flight request without counting it
            r_state   <= ST_IDLE;
            cpl_start <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_type <= req_type;
                        r_tag  <= req_tag;
                        r_rid  <= req_rid;
                        r_data <= req_data;
                        // 32-bit memory requests carry no upper address DW
                        r_addr <= (req_type[2:1] == 2'b00) ? {32'h0, req_addr[31:0]} : req_addr;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (r_type[2] & r_type[1]) begin
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        r_state <= ST_IDLE;
                    end else if (r_type[2]) begin
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        r_ur    <= 1'b1;
                        r_state <= ST_RDATA;
                    end else if (r_type[0]) begin
                        if (w_hit) begin
                            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                        end else begin
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        if (!w_hit && err_count != 8'hFF) err_count <= err_count + 8'd1;
                        r_ur    <= ~w_hit;
                        r_state <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    cpl_start      <= 1'b1;
                    cpl_tag        <= r_tag;
                    cpl_rid        <= r_rid;
                    cpl_lower_addr <= {r_addr[6:2], 2'b00};
                    if (r_ur) begin
                        cpl_type   <= 1'b0;
                        cpl_status <= 3'b001;
                        cpl_data   <= 32'd0;
                    end else begin
                        cpl_type   <= 1'b1;
                        cpl_status <= 3'b000;
                        cpl_data   <= r_rdata;
                        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                    end
                    r_state <= ST_CPL_WAIT;
                end
                ST_CPL_WAIT: begin
                    cpl_start <= 1'b0;
                    if (cpl_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_target_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_target_responder
// Brief    : Scoreboard bench for pio_target_responder request/completion flow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pio_target_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          DW   = 256;

    logic        user_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        user_lnk_up = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_type = 3'd0;
    logic [7:0]  req_tag = 8'd0;
    logic [15:0] req_rid = 16'd0;
    logic [63:0] req_addr = 64'd0;
    logic [31:0] req_data = 32'd0;
    logic        cpl_start, cpl_type;
    logic [2:0]  cpl_status;
    logic [7:0]  cpl_tag;
    logic [15:0] cpl_rid;
    logic [6:0]  cpl_lower_addr;
    logic [31:0] cpl_data;
    logic        cpl_done = 1'b1;
    logic [15:0] wr_count, rd_count;
    logic [7:0]  err_count;

    pio_target_responder #(.BAR_BASE(32'h8000_0000), .MEM_DW(DW)) dut (
        .user_clk(user_clk), .reset_n(reset_n), .user_lnk_up(user_lnk_up),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_tag(req_tag), .req_rid(req_rid), .req_addr(req_addr), .req_data(req_data),
        .cpl_start(cpl_start), .cpl_type(cpl_type), .cpl_status(cpl_status),
        .cpl_tag(cpl_tag), .cpl_rid(cpl_rid), .cpl_lower_addr(cpl_lower_addr),
        .cpl_data(cpl_data), .cpl_done(cpl_done), .wr_count(wr_count),
        .rd_count(rd_count), .err_count(err_count)
    );

    always #5 user_clk = ~user_clk;

    typedef struct packed {
        logic        t;
        logic [2:0]  st;
        logic [7:0]  tag;
        logic [15:0] rid;
        logic [6:0]  la;
        logic [31:0] d;
    } cpl_t;

    cpl_t        sb[$];
    logic [31:0] mdl[int];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          acc_neg = 0;
    int          exp_wr = 0, exp_rd = 0, exp_err = 0;

    always @(posedge user_clk) cyc <= cyc + 1;

    // Completion monitor: every cpl_start must match the oldest expectation
    always @(negedge user_clk) begin
        if (cpl_start) begin
            cpl_t got, exp;
            got = {cpl_type, cpl_status, cpl_tag, cpl_rid, cpl_lower_addr, cpl_data};
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_cpl got=%h required none", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL cpl_fields got=%h required=%h", got, exp);
                end
                n_checks++;
                if (cyc - acc_neg !== 2) begin
                    n_errors++;
                    $display("FAIL cpl_latency got=%0d required=2", cyc - acc_neg);
                end
            end
        end
    end

    task automatic model_req(input logic [2:0] t, input logic [7:0] tag, input logic [15:0] rid,
                             input logic [63:0] a, input logic [31:0] d);
        logic [63:0] ea;
        logic        hit;
        int          idx;
        ea = (t[2:1] == 2'b00) ? {32'h0, a[31:0]} : a;
        ea[1:0] = 2'b00;
        hit = (ea >= BASE) && (ea < BASE + 64'(DW * 4));
        idx = hit ? int'((ea - BASE) >> 2) : 0;
        case (t)
            3'b000, 3'b010: begin
                if (hit) begin
                    sb.push_back({1'b1, 3'b000, tag, rid, a[6:2], 2'b00, mdl[idx]});
                    exp_rd++;
                end else begin
                    sb.push_back({1'b0, 3'b001, tag, rid, a[6:2], 2'b00, 32'h0});
                    exp_err++;
                end
            end
            3'b001, 3'b011: begin
                if (hit) begin
                    mdl[idx] = d;
                    exp_wr++;
                end else begin
                    exp_err++;
                end
            end
            3'b100, 3'b101: begin
                sb.push_back({1'b0, 3'b001, tag, rid, a[6:2], 2'b00, 32'h0});
                exp_err++;
            end
            default: exp_err++;
        endcase
    endtask

    // Present one request, wait (bounded) for acceptance, then record it in the model
    task automatic send(input logic [2:0] t, input logic [7:0] tag, input logic [15:0] rid,
                        input logic [63:0] a, input logic [31:0] d, input bit commit);
        int w;
        @(negedge user_clk);
        req_type = t; req_tag = tag; req_rid = rid; req_addr = a; req_data = d;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge user_clk);
            w++;
        end
        n_checks++;
        if (!req_ready) begin
            n_errors++;
            $display("FAIL accept_timeout tag=%h got ready=%b required 1", tag, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge user_clk);
        @(negedge user_clk);
        req_valid = 1'b0;
        acc_neg = cyc;
        if (commit) model_req(t, tag, rid, a, d);
    endtask

    task automatic drain(input bit need_ready);
        int w;
        w = 0;
        while ((sb.size() != 0 || (need_ready && !req_ready)) && w < 100) begin
            @(negedge user_clk);
            w++;
        end
        n_checks++;
        if (sb.size() != 0 || (need_ready && !req_ready)) begin
            n_errors++;
            $display("FAIL drain_timeout pending=%0d ready=%b required 0 pending", sb.size(), req_ready);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge user_clk);
        n_checks++;
        if ({req_ready, cpl_start, cpl_type, cpl_status, cpl_tag, cpl_rid, cpl_lower_addr,
             cpl_data, wr_count, rd_count, err_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got ready=%b start=%b wr=%h rd=%h err=%h required all 0",
                     req_ready, cpl_start, wr_count, rd_count, err_count);
        end
        reset_n = 1'b1;
        @(negedge user_clk);
    endtask

    task automatic test_write_read;
        send(3'b001, 8'h01, 16'h0ABC, 64'h8000_0010, 32'h1234_5678, 1'b1);
        send(3'b000, 8'h05, 16'h0ABC, 64'h8000_0010, 32'h0, 1'b1);
        drain(1'b1);
        n_checks++;
        if ({wr_count, rd_count, err_count} !== {16'(exp_wr), 16'(exp_rd), 8'(exp_err)}) begin
            n_errors++;
            $display("FAIL counters_wr_rd got=%h/%h/%h required=%0d/%0d/%0d",
                     wr_count, rd_count, err_count, exp_wr, exp_rd, exp_err);
        end
    endtask

    task automatic test_miss;
        send(3'b000, 8'h22, 16'h0100, 64'h9000_0000, 32'h0, 1'b1);
        drain(1'b1);
        n_checks++;
        if (err_count !== 8'd1) begin
            n_errors++;
            $display("FAIL miss_err_count got=%0d required=1", err_count);
        end
    endtask

    task automatic test_boundary;
        send(3'b001, 8'h30, 16'h0200, 64'h8000_03FC, 32'hA5A5_A5A5, 1'b1);
        send(3'b001, 8'h31, 16'h0200, 64'h8000_0400, 32'hFFFF_FFFF, 1'b1);
        send(3'b000, 8'h33, 16'h0200, 64'h8000_03FC, 32'h0, 1'b1);
        send(3'b010, 8'h34, 16'h0200, 64'h1_8000_0000, 32'h0, 1'b1);
        send(3'b000, 8'h35, 16'h0200, 64'h1_8000_0010, 32'h0, 1'b1);
        drain(1'b1);
        n_checks++;
        if ({wr_count, rd_count, err_count} !== {16'(exp_wr), 16'(exp_rd), 8'(exp_err)}) begin
            n_errors++;
            $display("FAIL counters_boundary got=%h/%h/%h required=%0d/%0d/%0d",
                     wr_count, rd_count, err_count, exp_wr, exp_rd, exp_err);
        end
    endtask

    task automatic test_io_illegal;
        send(3'b100, 8'h07, 16'h0300, 64'h8000_0010, 32'h0, 1'b1);
        drain(1'b1);
        send(3'b111, 8'h08, 16'h0300, 64'h8000_0010, 32'h0, 1'b1);
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_ready_c1 got=%b required=0", req_ready);
        end
        @(negedge user_clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_ready_c2 got=%b required=1", req_ready);
        end
        n_checks++;
        if (err_count !== 8'(exp_err)) begin
            n_errors++;
            $display("FAIL illegal_err_count got=%0d required=%0d", err_count, exp_err);
        end
    endtask

    task automatic test_back_to_back;
        int a0;
        send(3'b001, 8'h10, 16'h0400, 64'h8000_0020, 32'hDEAD_BEEF, 1'b1);
        a0 = acc_neg;
        send(3'b011, 8'h11, 16'h0400, 64'h8000_0024, 32'hCAFE_F00D, 1'b1);
        n_checks++;
        if (acc_neg - a0 !== 2) begin
            n_errors++;
            $display("FAIL write_rate got=%0d cycles required=2", acc_neg - a0);
        end
        send(3'b000, 8'h12, 16'h0400, 64'h8000_0020, 32'h0, 1'b1);
        send(3'b010, 8'h13, 16'h0400, 64'h8000_0024, 32'h0, 1'b1);
        drain(1'b1);
    endtask

    task automatic test_cpl_hold;
        cpl_done = 1'b0;
        send(3'b000, 8'h40, 16'h0500, 64'h8000_0020, 32'h0, 1'b1);
        drain(1'b0);
        @(negedge user_clk);
        req_type = 3'b000; req_tag = 8'h41; req_rid = 16'h0500;
        req_addr = 64'h8000_0024; req_data = 32'h0; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (req_ready !== 1'b0 || cpl_tag !== 8'h40) begin
                n_errors++;
                $display("FAIL hold_cycle%0d got ready=%b tag=%h required ready=0 tag=40",
                         i, req_ready, cpl_tag);
            end
            @(negedge user_clk);
        end
        cpl_done = 1'b1;
        @(negedge user_clk);
        cpl_done = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_release got ready=%b required=1", req_ready);
        end
        @(posedge user_clk);
        @(negedge user_clk);
        req_valid = 1'b0;
        acc_neg = cyc;
        model_req(3'b000, 8'h41, 16'h0500, 64'h8000_0024, 32'h0);
        drain(1'b0);
        cpl_done = 1'b1;
        drain(1'b1);
    endtask

    task automatic test_link_down;
        cpl_done = 1'b0;
        send(3'b000, 8'h50, 16'h0600, 64'h8000_0010, 32'h0, 1'b1);
        drain(1'b0);
        @(negedge user_clk);
        user_lnk_up = 1'b0;
        @(negedge user_clk);
        n_checks++;
        if (req_ready !== 1'b0 || cpl_start !== 1'b0) begin
            n_errors++;
            $display("FAIL link_down got ready=%b start=%b required 0/0", req_ready, cpl_start);
        end
        user_lnk_up = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL relink_idle got ready=%b required=1", req_ready);
        end
        cpl_done = 1'b1;
        send(3'b000, 8'h51, 16'h0600, 64'h8000_0010, 32'h0, 1'b1);
        drain(1'b1);
        // Request abandoned in ST_DECODE must not complete or count
        send(3'b000, 8'h52, 16'h0600, 64'h8000_0010, 32'h0, 1'b0);
        user_lnk_up = 1'b0;
        repeat (2) @(negedge user_clk);
        user_lnk_up = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, wr_count, rd_count, err_count} !==
            {1'b1, 16'(exp_wr), 16'(exp_rd), 8'(exp_err)}) begin
            n_errors++;
            $display("FAIL link_drop_discard got ready=%b %h/%h/%h required 1 %0d/%0d/%0d",
                     req_ready, wr_count, rd_count, err_count, exp_wr, exp_rd, exp_err);
        end
    endtask

    task automatic test_reset_mid_read;
        send(3'b000, 8'h60, 16'h0700, 64'h8000_0010, 32'h0, 1'b0);
        reset_n = 1'b0;
        @(negedge user_clk);
        n_checks++;
        if ({req_ready, cpl_start, cpl_type, cpl_status, cpl_tag, cpl_rid, cpl_lower_addr,
             cpl_data, wr_count, rd_count, err_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_read got start=%b tag=%h wr=%h rd=%h err=%h required all 0",
                     cpl_start, cpl_tag, wr_count, rd_count, err_count);
        end
        @(negedge user_clk);
        reset_n = 1'b1;
        exp_wr = 0; exp_rd = 0; exp_err = 0;
        send(3'b000, 8'h61, 16'h0700, 64'h8000_0010, 32'h0, 1'b1);
        drain(1'b1);
        n_checks++;
        if (rd_count !== 16'd1) begin
            n_errors++;
            $display("FAIL post_reset_rd_count got=%0d required=1", rd_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_miss();
        test_boundary();
        test_io_illegal();
        test_back_to_back();
        test_cpl_hold();
        test_link_down();
        test_reset_mid_read();
        repeat (3) @(negedge user_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
